// File: rtl/rns_compare_scheduler_9_8_7_pkg.sv
// Shared constants and types for the {9,8,7} RNS compare scheduler.
// Holds the moduli, the mixed-radix inverses and weights, and the FSM state encoding.
package rns_987_pkg;

    localparam int unsigned M1 = 9;
    localparam int unsigned M2 = 8;
    localparam int unsigned M3 = 7;

    localparam int unsigned INV_9_MOD8 = 1;
    localparam int unsigned INV_9_MOD7 = 4;
    localparam int unsigned INV_8_MOD7 = 1;

    localparam int unsigned W2 = 9;
    localparam int unsigned W3 = 72;
    localparam int unsigned DYN_RANGE = 504;

    localparam int unsigned A1_W  = 4;
    localparam int unsigned A2_W  = 3;
    localparam int unsigned A3_W  = 3;
    localparam int unsigned V2_W  = $clog2(M2);
    localparam int unsigned V3_W  = $clog2(M3);
    localparam int unsigned VAL_W = $clog2(DYN_RANGE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV1 = 3'd1,
        ST_CONV2 = 3'd2,
        ST_CMP   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/rns_compare_scheduler_9_8_7_rr_arbiter.sv
// Combinational round-robin arbiter: the winner is the first valid bit
// above ptr, wrapping around to bit 0 and ending at ptr itself.
module rns_rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    valid,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] win_id,
    output logic            any
);

    int unsigned ptr_u;

    always_comb begin
        grant  = '0;
        win_id = '0;
        any    = 1'b0;
        ptr_u  = 32'(ptr);
        // Requesters above the pointer go first, then the wrap-around half.
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && (i > ptr_u) && valid[i]) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                win_id   = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && (i <= ptr_u) && valid[i]) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                win_id   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/rns_compare_scheduler_9_8_7.sv
// Shared sequential RNS{9,8,7}-to-binary converter and threshold comparator,
// time-multiplexed across NUM_REQ requesters by a round-robin arbiter.
module rns_compare_scheduler_9_8_7
    import rns_987_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned THRESH_RST = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [A1_W*NUM_REQ-1:0]  req_a1,
    input  logic [A2_W*NUM_REQ-1:0]  req_a2,
    input  logic [A3_W*NUM_REQ-1:0]  req_a3,
    input  logic                     cfg_we,
    input  logic [VAL_W-1:0]         cfg_thresh,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [VAL_W-1:0]         resp_value,
    output logic                     resp_le,
    output logic                     resp_eq,
    output logic                     resp_gr,
    output logic                     resp_err,
    output logic                     busy
);

    state_t state, state_next;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    ptr;
    logic               any_valid;
    logic               accept_c;

    logic [A1_W-1:0] a1_arr [NUM_REQ];
    logic [A2_W-1:0] a2_arr [NUM_REQ];
    logic [A3_W-1:0] a3_arr [NUM_REQ];
    logic [A1_W-1:0] sel_a1;
    logic [A2_W-1:0] sel_a2;
    logic [A3_W-1:0] sel_a3;

    logic [A1_W-1:0]  a1_q;
    logic [A2_W-1:0]  a2_q;
    logic [A3_W-1:0]  a3_q;
    logic [ID_W-1:0]  id_q;
    logic [VAL_W-1:0] thresh;
    logic [VAL_W-1:0] thr_q;
    logic [A1_W-1:0]  v1_q;
    logic [V2_W-1:0]  v2_q;
    logic [V3_W-1:0]  v3_q;

    int unsigned a1_u, a2_u, a3_u, v1_u, v2_u, v3_u, d7_u, x_u, thr_u;
    logic [V2_W-1:0]  v2_c;
    logic [V3_W-1:0]  v3_c;
    logic [VAL_W-1:0] x_c;
    logic             err_c;

    rns_rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .valid  (req_valid),
        .ptr    (ptr),
        .grant  (grant),
        .win_id (win_id),
        .any    (any_valid)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a1_arr[g] = req_a1[g*A1_W +: A1_W];
        assign a2_arr[g] = req_a2[g*A2_W +: A2_W];
        assign a3_arr[g] = req_a3[g*A3_W +: A3_W];
    end

    // One-hot OR mux of the granted requester's residues.
    always_comb begin
        sel_a1 = '0;
        sel_a2 = '0;
        sel_a3 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a1 = sel_a1 | a1_arr[i];
                sel_a2 = sel_a2 | a2_arr[i];
                sel_a3 = sel_a3 | a3_arr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (any_valid) state_next = ST_CONV1;
            ST_CONV1: state_next = ST_CONV2;
            ST_CONV2: state_next = ST_CMP;
            ST_CMP:   state_next = ST_RESP;
            ST_RESP:  if (resp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        accept_c  = 1'b0;
        if (state == ST_IDLE) begin
            req_ready = grant;
            accept_c  = any_valid;
        end
    end

    // Mixed-radix digits and reconstruction; the bias of 3*M3 keeps the mod-7
    // difference non-negative even for out-of-range residues.
    always_comb begin
        a1_u  = 32'(a1_q);
        a2_u  = 32'(a2_q);
        a3_u  = 32'(a3_q);
        v1_u  = 32'(v1_q);
        v2_u  = 32'(v2_q);
        v3_u  = 32'(v3_q);
        thr_u = 32'(thr_q);
        v2_c  = V2_W'((a2_u - a1_u) * INV_9_MOD8);
        d7_u  = (a3_u + 3 * M3 - v1_u) % M3;
        v3_c  = V3_W'((INV_8_MOD7 * (INV_9_MOD7 * d7_u + M3 - (v2_u % M3))) % M3);
        x_u   = v1_u + W2 * v2_u + W3 * v3_u;
        x_c   = VAL_W'(x_u);
        err_c = (a1_u >= M1) || (a3_u >= M3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh     <= VAL_W'(THRESH_RST);
            ptr        <= ID_W'(NUM_REQ - 1);
            a1_q       <= '0;
            a2_q       <= '0;
            a3_q       <= '0;
            id_q       <= '0;
            thr_q      <= '0;
            v1_q       <= '0;
            v2_q       <= '0;
            v3_q       <= '0;
            resp_id    <= '0;
            resp_value <= '0;
            resp_le    <= 1'b0;
            resp_eq    <= 1'b0;
            resp_gr    <= 1'b0;
            resp_err   <= 1'b0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (cfg_we) thresh <= cfg_thresh;
            if (accept_c) begin
                a1_q  <= sel_a1;
                a2_q  <= sel_a2;
                a3_q  <= sel_a3;
                id_q  <= win_id;
                thr_q <= thresh;
                ptr   <= win_id;
            end
            if (state == ST_CONV1) begin
                v1_q <= a1_q;
                v2_q <= v2_c;
            end
            if (state == ST_CONV2) v3_q <= v3_c;
            if (state == ST_CMP) begin
                resp_id    <= id_q;
                resp_err   <= err_c;
                resp_value <= err_c ? '0 : x_c;
                resp_le    <= !err_c && (x_u <  thr_u);
                resp_eq    <= !err_c && (x_u == thr_u);
                resp_gr    <= !err_c && (x_u >  thr_u);
            end
            resp_valid <= (state_next == ST_RESP);
            busy       <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: doc/rns_compare_scheduler_9_8_7.md
Name: rns_compare_scheduler_9_8_7

Overview:
- Shares one sequential RNS-to-binary compare engine for moduli {9,8,7} among NUM_REQ requesters.
- Requesters present residue triples. A round-robin arbiter grants one request at a time.
- The engine runs a 3-step mixed-radix conversion, then compares the 9-bit binary value to a programmable threshold.
- The result returns on a single valid/ready response channel tagged with the requester id.
- Sits between RNS datapath clients and the threshold-check function; replaces per-client combinational reverse converters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of resp_id; must be at least clog2(NUM_REQ).
- THRESH_RST, 10, threshold value loaded at reset (0..511).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept; at most one bit high.
- req_a1  in  4*NUM_REQ  residue mod 9, requester i at [4i+3:4i].
- req_a2  in  3*NUM_REQ  residue mod 8, requester i at [3i+2:3i].
- req_a3  in  3*NUM_REQ  residue mod 7, requester i at [3i+2:3i].
- cfg_we  in  1  threshold write strobe.
- cfg_thresh  in  9  new threshold value.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  ID_W  index of the requester served.
- resp_value  out  9  reconstructed binary value, 0..503.
- resp_le  out  1  value < threshold.
- resp_eq  out  1  value == threshold.
- resp_gr  out  1  value > threshold.
- resp_err  out  1  invalid residue (a1>8 or a3>6).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: FSM=IDLE; req_ready=0; resp_valid=0; all resp_* outputs=0; busy=0; threshold=THRESH_RST; round-robin pointer=NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE -> CONV1 -> CONV2 -> CMP -> RESP -> IDLE.
- IDLE: if any req_valid is set, req_ready is driven combinationally one-hot to the winner.
  - Winner = first set bit scanning upward from pointer+1, with wrap-around.
  - Accept edge: latch the winner's residues, the winner's id, and the current threshold. Update the pointer to the winner. Go to CONV1.
  - No valid: stay in IDLE; req_ready=0.
- CONV1: v1=a1; v2=(a2-a1) mod 8 (3-bit wrap of the difference); register both.
- CONV2: v3=(4*(a3-v1) - v2) mod 7, computed with non-negative mod-7 reduction; register.
- CMP: X = v1 + 9*v2 + 72*v3, 9 bits, maximum 503; register X and the three flags against the latched threshold.
- RESP: resp_valid=1. All resp_* outputs hold stable until resp_ready=1. On handshake go to IDLE; resp_valid drops the next cycle.
- Latency: accept in cycle 0; resp_valid high from cycle 4. Minimum 5 cycles per transaction, with no overlap.
- req_ready is always 0 outside IDLE.
- Error: if a1>8 or a3>6, then resp_err=1, resp_le=resp_eq=resp_gr=0 and resp_value=0. The request still consumes the full latency.
- Exactly one of le/eq/gr is 1 when resp_err=0.
- Threshold ≥504 is legal: every valid input gives le=1.
- Threshold write:
  - cfg_we updates the threshold register at the clock edge in any state.
  - An in-flight transaction uses the threshold latched at its accept edge.
  - A write in the same cycle as an accept is not seen by that transaction; it applies to the next one.
- Requester dropping req_valid before grant: no effect. Requester dropping req_valid while granted: not allowed (protocol violation, assert in bench).
- rst_n asserted mid-operation: immediate return to the reset values above; the in-flight transaction is discarded with no response.

Decomposition:
- Package rns_987_pkg holds:
  - moduli constants M1=9, M2=8, M3=7;
  - mixed-radix inverse constants INV_9_MOD8=1, INV_9_MOD7=4, INV_8_MOD7=1;
  - weights W2=9, W3=72;
  - DYN_RANGE=504;
  - FSM state enum typedef;
  - residue width constants.
- One sub-module: rns_rr_arbiter (parametric round-robin grant from valid vector plus pointer, purely combinational). The conversion steps stay inline in the scheduler.

Test Plan:
- Single request, requester 0, residues (1,2,3), reset threshold 10 -> req_ready[0] in cycle 0; resp_valid in cycle 4; resp_value=10, eq=1, le=gr=0, id=0.
- Residues (8,7,6) with threshold 10 -> value 503, gr=1. Residues (0,0,0) -> value 0, le=1.
- All four requesters valid continuously, each with distinct residues -> grants in order 0,1,2,3,0. Each response id matches its grant; no requester starves.
- Hold resp_ready=0 for 6 cycles in RESP -> outputs stable; no new req_ready; on resp_ready=1, the next grant is issued the cycle after RESP exits.
- cfg_we with thresh=200 asserted in the accept cycle of the value-300 transaction -> that response is compared against 10 (gr=1); the next value-150 request gets le=1.
- Residues (12,0,0) -> resp_err=1, all flags 0. Separately, rst_n pulsed low in CONV2 -> resp_valid never rises; threshold returns to 10.
